// File: rtl/instr_register_pkg.sv
// ============================================================================
// instr_register_pkg : shared instruction/result types and execution states
// Rev 1.0
// ============================================================================
`default_nettype none

package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result;
    typedef logic        [5:0]  address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT_RD = 3'd2,
        ISSUE   = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } exec_state_t;

    localparam logic [3:0] OPC_MAX = 4'd7;

endpackage

`default_nettype wire

// File: rtl/instr_alu_watchdog.sv
// ============================================================================
// instr_alu_watchdog : cycle counter flagging an ALU request left unacknowledged
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_alu_watchdog #(
    parameter int ALU_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             CW     = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;
    localparam logic [CW-1:0]  c_last = CW'(ALU_TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires on the last permitted cycle of the request, not one after it.
    assign expired = enable && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/instr_exec_ctrl.sv
// ============================================================================
// instr_exec_ctrl : walks an address range of stored instructions, runs each
// through the shared ALU and writes the result back. Rev 1.0
// ============================================================================
`default_nettype none

module instr_exec_ctrl
    import instr_register_pkg::*;
#(
    parameter int ALU_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    input  address_t     first_addr,
    input  address_t     last_addr,
    output address_t     rd_addr,
    input  instruction_t rd_data,
    output logic         alu_req,
    output opcode_t      alu_opc,
    output operand_t     alu_a,
    output operand_t     alu_b,
    input  logic         alu_ack,
    input  result        alu_res,
    output logic         wb_en,
    output address_t     wb_addr,
    output result        wb_res,
    output logic         busy,
    output logic         done,
    output logic         err_illegal,
    output logic         err_div0,
    output logic         err_timeout
);

    exec_state_t  r_state;
    exec_state_t  w_next;
    address_t     r_cur;
    address_t     r_last;
    instruction_t r_instr;
    result        r_result;
    logic         r_err_illegal;
    logic         r_err_div0;
    logic         r_err_timeout;

    logic         w_illegal;
    logic         w_div0;
    logic         w_expired;
    logic [3:0]   w_opc_bits;

    assign w_opc_bits = rd_data.opc;
    assign w_illegal  = (w_opc_bits > OPC_MAX);
    assign w_div0     = ((rd_data.opc == DIV) || (rd_data.opc == MOD)) && (rd_data.op_b == '0);

    instr_alu_watchdog #(
        .ALU_TIMEOUT (ALU_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (r_state != ISSUE),
        .enable  (r_state == ISSUE),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FETCH;
            FETCH:   w_next = WAIT_RD;
            WAIT_RD: w_next = (w_illegal || w_div0) ? WRITE : ISSUE;
            // An ack arriving on the expiry cycle still counts as a real result.
            ISSUE:   if (alu_ack || w_expired) w_next = WRITE;
            WRITE:   w_next = (r_cur == r_last) ? DONE : FETCH;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (abort && (r_state != IDLE)) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cur         <= '0;
            r_last        <= '0;
            r_instr       <= '0;
            r_result      <= '0;
            r_err_illegal <= 1'b0;
            r_err_div0    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_cur         <= first_addr;
                r_last        <= last_addr;
                r_err_illegal <= 1'b0;
                r_err_div0    <= 1'b0;
                r_err_timeout <= 1'b0;
            end
        end else if (!abort) begin
            case (r_state)
                WAIT_RD: begin
                    r_instr <= rd_data;
                    if (w_illegal) begin
                        r_result      <= '0;
                        r_err_illegal <= 1'b1;
                    end else if (w_div0) begin
                        r_result   <= '0;
                        r_err_div0 <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (alu_ack) begin
                        r_result <= alu_res;
                    end else if (w_expired) begin
                        r_result      <= '0;
                        r_err_timeout <= 1'b1;
                    end
                end
                WRITE: begin
                    if (r_cur != r_last) begin
                        r_cur <= r_cur + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_addr = '0;
        alu_req = 1'b0;
        alu_opc = ZERO;
        alu_a   = '0;
        alu_b   = '0;
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_res  = '0;
        done    = 1'b0;
        busy    = (r_state != IDLE);
        case (r_state)
            FETCH: rd_addr = r_cur;
            ISSUE: begin
                alu_req = 1'b1;
                alu_opc = r_instr.opc;
                alu_a   = r_instr.op_a;
                alu_b   = r_instr.op_b;
            end
            WRITE: begin
                wb_en   = 1'b1;
                wb_addr = r_cur;
                wb_res  = r_result;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign err_illegal = r_err_illegal;
    assign err_div0    = r_err_div0;
    assign err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_instr_exec_ctrl.sv
// ============================================================================
// tb_instr_exec_ctrl : directed self-checking bench for instr_exec_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_exec_ctrl;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    address_t     first_addr = '0;
    address_t     last_addr = '0;
    address_t     rd_addr;
    instruction_t rd_data;
    logic         alu_req;
    opcode_t      alu_opc;
    operand_t     alu_a;
    operand_t     alu_b;
    logic         alu_ack;
    result        alu_res;
    logic         wb_en;
    address_t     wb_addr;
    result        wb_res;
    logic         busy;
    logic         done;
    logic         err_illegal;
    logic         err_div0;
    logic         err_timeout;

    instruction_t mem [64];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic         alu_en = 1'b0;
    int           ack_delay = 1;
    int           reqcnt = 0;

    address_t     wb_addr_q [$];
    result        wb_res_q  [$];
    int           req_runs  [$];
    int           req_run = 0;
    int           done_cnt = 0;

    always #5 clk = ~clk;

    instr_exec_ctrl #(.ALU_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .first_addr  (first_addr),
        .last_addr   (last_addr),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .alu_req     (alu_req),
        .alu_opc     (alu_opc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ack     (alu_ack),
        .alu_res     (alu_res),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_res      (wb_res),
        .busy        (busy),
        .done        (done),
        .err_illegal (err_illegal),
        .err_div0    (err_div0),
        .err_timeout (err_timeout)
    );

    function automatic result alu_model(input opcode_t o, input operand_t a, input operand_t b);
        case (o)
            PASSA:   return result'(a);
            PASSB:   return result'(b);
            ADD:     return result'(a) + result'(b);
            SUB:     return result'(a) - result'(b);
            MULT:    return result'(a) * result'(b);
            default: return '0;
        endcase
    endfunction

    function automatic instruction_t mk(input opcode_t o, input operand_t a, input operand_t b);
        instruction_t t;
        t.opc  = o;
        t.op_a = a;
        t.op_b = b;
        return t;
    endfunction

    // Instruction memory with one-cycle read latency, plus a simple ALU model.
    always @(posedge clk) rd_data <= mem[rd_addr];
    always @(posedge clk) reqcnt  <= (alu_req && !alu_ack) ? reqcnt + 1 : 0;
    assign alu_ack = alu_en && alu_req && (reqcnt == ack_delay);
    assign alu_res = alu_model(alu_opc, alu_a, alu_b);

    always @(negedge clk) begin
        if (wb_en) begin
            wb_addr_q.push_back(wb_addr);
            wb_res_q.push_back(wb_res);
        end
        if (done) done_cnt++;
        if (alu_req) begin
            req_run++;
        end else if (req_run > 0) begin
            req_runs.push_back(req_run);
            req_run = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_range(input address_t f, input address_t l);
        @(negedge clk);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && (k < 400)) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    int m, rm, d0, k;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[5]  = mk(ADD, 32'sd7, -32'sd3);
        mem[62] = mk(PASSA, 32'sd100, 32'sd0);
        mem[63] = mk(PASSA, 32'sd101, 32'sd0);
        mem[0]  = mk(PASSA, 32'sd102, 32'sd0);
        mem[1]  = mk(PASSA, 32'sd103, 32'sd0);
        mem[3]  = mk(DIV, 32'sd10, 32'sd0);
        mem[4]  = 68'hC_00000001_00000002;
        mem[7]  = mk(MULT, 32'sd3, 32'sd5);
        mem[8]  = mk(SUB, 32'sd9, 32'sd4);
        mem[10] = mk(ADD, 32'sd1, 32'sd2);
        mem[11] = mk(ADD, 32'sd4, 32'sd4);
        mem[20] = mk(DIV, 32'sd5, 32'sd0);
        mem[21] = mk(ADD, 32'sd1, 32'sd1);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_alu_req", 64'(alu_req), 64'd0);
        check("rst_wb_en", 64'(wb_en), 64'd0);
        check("rst_flags", {61'd0, err_illegal, err_div0, err_timeout}, 64'd0);
        reset_n = 1'b1;

        // Single ADD at 5, ALU acks on the second request cycle
        alu_en = 1'b1; ack_delay = 1;
        m = wb_addr_q.size(); rm = req_runs.size(); d0 = done_cnt;
        run_range(6'd5, 6'd5);
        wait_idle("t1_idle");
        check("t1_wb_cnt", 64'(wb_addr_q.size() - m), 64'd1);
        check("t1_wb_addr", 64'(wb_addr_q[m]), 64'd5);
        check("t1_wb_res", wb_res_q[m], 64'd4);
        check("t1_done", 64'(done_cnt - d0), 64'd1);
        check("t1_req_len", 64'(req_runs[rm]), 64'd2);
        check("t1_flags", {61'd0, err_illegal, err_div0, err_timeout}, 64'd0);

        // Wrapping range 62..1 with a stray start while busy
        m = wb_addr_q.size(); d0 = done_cnt;
        run_range(6'd62, 6'd1);
        repeat (3) @(negedge clk);
        first_addr = 6'd20; last_addr = 6'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t2_idle");
        check("t2_wb_cnt", 64'(wb_addr_q.size() - m), 64'd4);
        check("t2_addr0", 64'(wb_addr_q[m]),   64'd62);
        check("t2_addr1", 64'(wb_addr_q[m+1]), 64'd63);
        check("t2_addr2", 64'(wb_addr_q[m+2]), 64'd0);
        check("t2_addr3", 64'(wb_addr_q[m+3]), 64'd1);
        check("t2_res0", wb_res_q[m],   64'd100);
        check("t2_res3", wb_res_q[m+3], 64'd103);
        check("t2_done", 64'(done_cnt - d0), 64'd1);

        // Divide-by-zero at 3, illegal opcode at 4: no ALU traffic
        m = wb_addr_q.size(); rm = req_runs.size();
        run_range(6'd3, 6'd4);
        wait_idle("t3_idle");
        check("t3_no_req", 64'(req_runs.size() - rm), 64'd0);
        check("t3_wb_cnt", 64'(wb_addr_q.size() - m), 64'd2);
        check("t3_addr0", 64'(wb_addr_q[m]), 64'd3);
        check("t3_res0", wb_res_q[m], 64'd0);
        check("t3_addr1", 64'(wb_addr_q[m+1]), 64'd4);
        check("t3_res1", wb_res_q[m+1], 64'd0);
        check("t3_flags", {61'd0, err_illegal, err_div0, err_timeout}, 64'b110);

        // ALU never acknowledges: both instructions time out
        alu_en = 1'b0;
        m = wb_addr_q.size(); rm = req_runs.size();
        run_range(6'd7, 6'd8);
        wait_idle("t4_idle");
        check("t4_req_len0", 64'(req_runs[rm]),   64'd16);
        check("t4_req_len1", 64'(req_runs[rm+1]), 64'd16);
        check("t4_wb_cnt", 64'(wb_addr_q.size() - m), 64'd2);
        check("t4_addr1", 64'(wb_addr_q[m+1]), 64'd8);
        check("t4_res0", wb_res_q[m], 64'd0);
        check("t4_flags", {61'd0, err_illegal, err_div0, err_timeout}, 64'b001);

        // Abort on the same cycle as the ack at address 10
        alu_en = 1'b1; ack_delay = 2;
        m = wb_addr_q.size(); d0 = done_cnt;
        run_range(6'd10, 6'd11);
        k = 0;
        while (!alu_ack && (k < 50)) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("t5_ack_seen", 64'(alu_ack), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        #1;
        abort = 1'b0;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_req", 64'(alu_req), 64'd0);
        repeat (5) @(negedge clk);
        #1;
        check("t5_no_wb", 64'(wb_addr_q.size() - m), 64'd0);
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);

        // Reset while in ISSUE for address 21
        alu_en = 1'b0;
        m = wb_addr_q.size();
        run_range(6'd20, 6'd21);
        k = 0;
        while (!alu_req && (k < 50)) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("t6_in_issue", 64'(alu_req), 64'd1);
        check("t6_div0_set", 64'(err_div0), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_outs", {59'd0, alu_req, wb_en, done, rd_addr != 6'd0, wb_res != 64'd0}, 64'd0);
        check("t6_flags", {61'd0, err_illegal, err_div0, err_timeout}, 64'd0);
        check("t6_wb_cnt", 64'(wb_addr_q.size() - m), 64'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
